// File: rtl/ddr_cmd_sequencer_pkg.sv
// Shared definitions for the DDR command sequencer: host FILE_CMD codes, DDR bus
// encodings, sequencer states and the per-command beat helpers.
package ddr_cmd_sequencer_pkg;

    typedef logic       ulogic1;
    typedef logic [2:0] ulogic3;
    typedef logic [3:0] ulogic4;

    localparam int ROW_WIDTH  = 13;
    localparam int COL_WIDTH  = 10;
    localparam int BANK_WIDTH = 2;

    typedef enum ulogic3 {
        FC_NOP1 = 3'd0,
        FC_SCR  = 3'd1,
        FC_SCW  = 3'd2,
        FC_BLR  = 3'd3,
        FC_BLW  = 3'd4,
        FC_ATR  = 3'd5,
        FC_ATW  = 3'd6,
        FC_NOP2 = 3'd7
    } file_cmd_e;

    // {CS#,RAS#,CAS#,WE#}
    typedef enum ulogic4 {
        NOP_DDR      = 4'b0111,
        DDR_ACTIVATE = 4'b0011,
        DDR_READ     = 4'b0101,
        DDR_WRITE    = 4'b0100,
        DDR_PRECHRG  = 4'b0010
    } ddr_cmd_e;

    typedef enum ulogic4 {
        ST_IDLE     = 4'd0,
        ST_ACT      = 4'd1,
        ST_WAIT_RCD = 4'd2,
        ST_COL      = 4'd3,
        ST_WAIT_COL = 4'd4,
        ST_WAIT_PRE = 4'd5,
        ST_PRE      = 4'd6,
        ST_WAIT_RP  = 4'd7
    } seq_state_e;

    function automatic ulogic1 is_access(file_cmd_e c);
        case (c)
            FC_SCR, FC_SCW, FC_BLR, FC_BLW, FC_ATR, FC_ATW: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic ulogic1 is_block(file_cmd_e c);
        return (c == FC_BLR) || (c == FC_BLW);
    endfunction

    function automatic ulogic1 is_atomic(file_cmd_e c);
        return (c == FC_ATR) || (c == FC_ATW);
    endfunction

    // Direction of a column beat; atomics swap direction on their second beat.
    function automatic ulogic1 beat_is_write(file_cmd_e c, ulogic1 second);
        case (c)
            FC_SCW, FC_BLW: return 1'b1;
            FC_ATR:         return second;
            FC_ATW:         return !second;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ddr_cmd_sequencer_timing_counter.sv
// Shared wait-state down-counter: loads a value, counts to zero, flags done at zero.
// done_o is combinational from the count register; a load takes effect next cycle.
module ddr_timing_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Closed-page DDR sequencer: one host request -> ACTIVATE, column command(s), PRECHRG.
// All outputs registered; req_ready stays low from acceptance until tRP after PRECHRG.
module ddr_cmd_sequencer
    import ddr_cmd_sequencer_pkg::*;
#(
    parameter int unsigned T_RCD     = 3,
    parameter int unsigned T_CCD     = 4,
    parameter int unsigned T_RTP     = 2,
    parameter int unsigned T_WR      = 3,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_RTW     = 4,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_cmd_i,
    input  logic [BANK_WIDTH-1:0] req_bank_i,
    input  logic [ROW_WIDTH-1:0]  req_row_i,
    input  logic [COL_WIDTH-1:0]  req_col_i,
    input  logic [15:0]           req_data_i,
    output logic [3:0]            ddr_cmd_o,
    output logic [BANK_WIDTH-1:0] ddr_ba_o,
    output logic [ROW_WIDTH-1:0]  ddr_addr_o,
    output logic [15:0]           ddr_wdata_o,
    output logic                  ddr_wvalid_o
);

    localparam int CNT_W = 4;

    seq_state_e            state_q;
    file_cmd_e             cmd_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [COL_WIDTH-1:0]  col_q;
    logic [15:0]           data_q;
    logic [2:0]            beat_q;
    logic                  last_q;
    logic                  ready_q;
    ddr_cmd_e              ddr_cmd_q;
    logic [BANK_WIDTH-1:0] ddr_ba_q;
    logic [ROW_WIDTH-1:0]  ddr_addr_q;
    logic [15:0]           ddr_wdata_q;
    logic                  ddr_wvalid_q;

    file_cmd_e            req_cmd_e;
    logic                 accept;
    logic                 col_go;
    logic                 pre_go;
    logic                 cur_wr;
    logic                 last_beat;
    logic [2:0]           beats_m1;
    logic [COL_WIDTH-1:0] col_step;
    logic [15:0]          data_step;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_done;

    assign req_cmd_e = file_cmd_e'(req_cmd_i);

    // Each wait counter is loaded on the edge that issues its anchoring command.
    always_comb begin
        accept    = (state_q == ST_IDLE) && ready_q && req_valid_i;
        col_go    = ((state_q == ST_WAIT_RCD) || (state_q == ST_WAIT_COL)) && cnt_done;
        pre_go    = (state_q == ST_WAIT_PRE) && cnt_done;
        beats_m1  = 3'd0;
        if (is_block(cmd_q)) begin
            beats_m1 = 3'(BLOCK_LEN - 1);
        end else if (is_atomic(cmd_q)) begin
            beats_m1 = 3'd1;
        end
        last_beat = (beat_q == beats_m1);
        cur_wr    = beat_is_write(cmd_q, beat_q[0]);
        col_step  = is_block(cmd_q) ? COL_WIDTH'(8) : '0;
        data_step = is_block(cmd_q) ? 16'd1 : 16'd0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        if (accept && is_access(req_cmd_e)) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(T_RCD - 1);
        end else if (col_go) begin
            cnt_load = 1'b1;
            if (last_beat) begin
                cnt_val = cur_wr ? CNT_W'(T_WR - 1) : CNT_W'(T_RTP - 1);
            end else begin
                cnt_val = is_atomic(cmd_q) ? CNT_W'(T_RTW - 1) : CNT_W'(T_CCD - 1);
            end
        end else if (pre_go) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(T_RP - 1);
        end
    end

    ddr_timing_counter #(.WIDTH(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            cmd_q        <= FC_NOP1;
            bank_q       <= '0;
            col_q        <= '0;
            data_q       <= '0;
            beat_q       <= '0;
            last_q       <= 1'b0;
            ddr_cmd_q    <= NOP_DDR;
            ddr_ba_q     <= '0;
            ddr_addr_q   <= '0;
            ddr_wdata_q  <= '0;
            ddr_wvalid_q <= 1'b0;
        end else begin
            ddr_cmd_q    <= NOP_DDR;
            ddr_ba_q     <= '0;
            ddr_addr_q   <= '0;
            ddr_wdata_q  <= '0;
            ddr_wvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // NOP requests and unknown codes are consumed here with one idle cycle.
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        cmd_q   <= req_cmd_e;
                        bank_q  <= req_bank_i;
                        col_q   <= req_col_i;
                        data_q  <= req_data_i;
                        beat_q  <= '0;
                        if (is_access(req_cmd_e)) begin
                            state_q    <= ST_ACT;
                            ddr_cmd_q  <= DDR_ACTIVATE;
                            ddr_ba_q   <= req_bank_i;
                            ddr_addr_q <= req_row_i;
                        end
                    end
                end
                ST_ACT: state_q <= ST_WAIT_RCD;
                ST_WAIT_RCD, ST_WAIT_COL: begin
                    if (col_go) begin
                        state_q      <= ST_COL;
                        ddr_cmd_q    <= cur_wr ? DDR_WRITE : DDR_READ;
                        ddr_ba_q     <= bank_q;
                        ddr_addr_q   <= {{(ROW_WIDTH - COL_WIDTH){1'b0}}, col_q};
                        ddr_wdata_q  <= cur_wr ? data_q : '0;
                        ddr_wvalid_q <= cur_wr;
                        col_q        <= col_q + col_step;
                        data_q       <= data_q + data_step;
                        beat_q       <= beat_q + 1'b1;
                        last_q       <= last_beat;
                    end
                end
                ST_COL: state_q <= last_q ? ST_WAIT_PRE : ST_WAIT_COL;
                ST_WAIT_PRE: begin
                    if (pre_go) begin
                        state_q   <= ST_PRE;
                        ddr_cmd_q <= DDR_PRECHRG;
                        ddr_ba_q  <= bank_q;
                    end
                end
                ST_PRE: state_q <= ST_WAIT_RP;
                ST_WAIT_RP: begin
                    if (cnt_done) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign ddr_cmd_o    = ddr_cmd_q;
    assign ddr_ba_o     = ddr_ba_q;
    assign ddr_addr_o   = ddr_addr_q;
    assign ddr_wdata_o  = ddr_wdata_q;
    assign ddr_wvalid_o = ddr_wvalid_q;

    a_cmd_known: assert property (@(posedge clk_i) disable iff (reset_i)
        accept |-> !$isunknown(req_cmd_i));

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: request table plus back-to-back and reset corner cases.
module tb_ddr_cmd_sequencer;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;

    localparam logic [2:0] F_NOP1 = 3'd0;
    localparam logic [2:0] F_SCR  = 3'd1;
    localparam logic [2:0] F_SCW  = 3'd2;
    localparam logic [2:0] F_BLR  = 3'd3;
    localparam logic [2:0] F_BLW  = 3'd4;
    localparam logic [2:0] F_ATR  = 3'd5;
    localparam logic [2:0] F_ATW  = 3'd6;
    localparam logic [2:0] F_NOP2 = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [1:0]  req_bank;
    logic [12:0] req_row;
    logic [9:0]  req_col;
    logic [15:0] req_data;
    logic [3:0]  ddr_cmd;
    logic [1:0]  ddr_ba;
    logic [12:0] ddr_addr;
    logic [15:0] ddr_wdata;
    logic        ddr_wvalid;

    always #5 clk = ~clk;

    ddr_cmd_sequencer dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_cmd_i    (req_cmd),
        .req_bank_i   (req_bank),
        .req_row_i    (req_row),
        .req_col_i    (req_col),
        .req_data_i   (req_data),
        .ddr_cmd_o    (ddr_cmd),
        .ddr_ba_o     (ddr_ba),
        .ddr_addr_o   (ddr_addr),
        .ddr_wdata_o  (ddr_wdata),
        .ddr_wvalid_o (ddr_wvalid)
    );

    typedef struct packed {
        logic [2:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic [15:0] dat;
        int          n_col;
        int          pre_off;
        int          rdy_off;
    } vec_t;

    typedef struct packed {
        int          vi;
        int          off;
        logic [3:0]  cmd;
        logic [9:0]  col;
        logic [15:0] dat;
    } beat_t;

    vec_t  vecs  [8];
    beat_t beats [14];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0]  log_cmd  [0:4095];
    logic [1:0]  log_ba   [0:4095];
    logic [12:0] log_addr [0:4095];
    logic [15:0] log_wdat [0:4095];
    logic        log_wv   [0:4095];
    logic        log_rdy  [0:4095];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 4096) begin
            log_cmd[cyc]  = ddr_cmd;
            log_ba[cyc]   = ddr_ba;
            log_addr[cyc] = ddr_addr;
            log_wdat[cyc] = ddr_wdata;
            log_wv[cyc]   = ddr_wvalid;
            log_rdy[cyc]  = req_ready;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        check("wait_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic int count_busy(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i <= to; i++) if (log_cmd[i] != C_NOP) n++;
        return n;
    endfunction

    function automatic int count_wv(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i <= to; i++) if (log_wv[i]) n++;
        return n;
    endfunction

    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] r,
                         input logic [9:0] col, input logic [15:0] d);
        req_cmd  = c;
        req_bank = b;
        req_row  = r;
        req_col  = col;
        req_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, exp_busy, exp_wv;

        // Offsets are relative to the acceptance cycle N.
        vecs[0] = '{F_SCR,  2'd1, 13'h0123, 10'h040, 16'h0000, 1, 6,  9};
        vecs[1] = '{F_SCW,  2'd2, 13'h0456, 10'h010, 16'hBEEF, 1, 7,  10};
        vecs[2] = '{F_BLR,  2'd3, 13'h1FFF, 10'h040, 16'h0000, 4, 18, 21};
        vecs[3] = '{F_BLW,  2'd0, 13'h0001, 10'h3FC, 16'hFFFF, 4, 19, 22};
        vecs[4] = '{F_ATR,  2'd1, 13'h0AAA, 10'h100, 16'h1234, 2, 11, 14};
        vecs[5] = '{F_ATW,  2'd2, 13'h1555, 10'h2AA, 16'hA5A5, 2, 10, 13};
        vecs[6] = '{F_NOP1, 2'd3, 13'h1234, 10'h155, 16'h5555, 0, 0,  2};
        vecs[7] = '{F_NOP2, 2'd1, 13'h0F0F, 10'h0AA, 16'hAAAA, 0, 0,  2};

        beats[0]  = '{0, 4,  C_RD, 10'h040, 16'h0000};
        beats[1]  = '{1, 4,  C_WR, 10'h010, 16'hBEEF};
        beats[2]  = '{2, 4,  C_RD, 10'h040, 16'h0000};
        beats[3]  = '{2, 8,  C_RD, 10'h048, 16'h0000};
        beats[4]  = '{2, 12, C_RD, 10'h050, 16'h0000};
        beats[5]  = '{2, 16, C_RD, 10'h058, 16'h0000};
        beats[6]  = '{3, 4,  C_WR, 10'h3FC, 16'hFFFF};
        beats[7]  = '{3, 8,  C_WR, 10'h004, 16'h0000};
        beats[8]  = '{3, 12, C_WR, 10'h00C, 16'h0001};
        beats[9]  = '{3, 16, C_WR, 10'h014, 16'h0002};
        beats[10] = '{4, 4,  C_RD, 10'h100, 16'h0000};
        beats[11] = '{4, 8,  C_WR, 10'h100, 16'h1234};
        beats[12] = '{5, 4,  C_WR, 10'h2AA, 16'hA5A5};
        beats[13] = '{5, 8,  C_RD, 10'h2AA, 16'h0000};

        reset     = 1'b1;
        req_valid = 1'b0;
        drive(F_NOP1, 2'd0, 13'd0, 10'd0, 16'd0);

        tick();
        tick();
        check("rst_ready",  32'(log_rdy[cyc]),  32'd0);
        check("rst_cmd",    32'(log_cmd[cyc]),  32'(C_NOP));
        check("rst_ba",     32'(log_ba[cyc]),   32'd0);
        check("rst_addr",   32'(log_addr[cyc]), 32'd0);
        check("rst_wdata",  32'(log_wdat[cyc]), 32'd0);
        check("rst_wvalid", 32'(log_wv[cyc]),   32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(log_rdy[cyc]), 32'd1);

        for (int v = 0; v < 8; v++) begin
            wait_ready();
            n = cyc;
            req_valid = 1'b1;
            drive(vecs[v].cmd, vecs[v].bank, vecs[v].row, vecs[v].col, vecs[v].dat);
            tick();
            req_valid = 1'b0;
            drive(3'd1, 2'd0, 13'h1FFF, 10'h3FF, 16'h0BAD);
            repeat (vecs[v].rdy_off - 1) tick();

            if (vecs[v].n_col > 0) begin
                check($sformatf("v%0d act_cmd", v),  32'(log_cmd[n + 1]),  32'(C_ACT));
                check($sformatf("v%0d act_ba", v),   32'(log_ba[n + 1]),   32'(vecs[v].bank));
                check($sformatf("v%0d act_row", v),  32'(log_addr[n + 1]), 32'(vecs[v].row));
                t = n + vecs[v].pre_off;
                check($sformatf("v%0d pre_cmd", v),  32'(log_cmd[t]),  32'(C_PRE));
                check($sformatf("v%0d pre_ba", v),   32'(log_ba[t]),   32'(vecs[v].bank));
                check($sformatf("v%0d pre_addr", v), 32'(log_addr[t]), 32'd0);
                exp_busy = vecs[v].n_col + 2;
            end else begin
                exp_busy = 0;
            end

            exp_wv = 0;
            for (int b = 0; b < 14; b++) begin
                if (beats[b].vi == v) begin
                    t = n + beats[b].off;
                    check($sformatf("v%0d b%0d cmd", v, b),  32'(log_cmd[t]),  32'(beats[b].cmd));
                    check($sformatf("v%0d b%0d ba", v, b),   32'(log_ba[t]),   32'(vecs[v].bank));
                    check($sformatf("v%0d b%0d addr", v, b), 32'(log_addr[t]), 32'(beats[b].col));
                    check($sformatf("v%0d b%0d wv", v, b),   32'(log_wv[t]),   32'(beats[b].cmd == C_WR));
                    if (beats[b].cmd == C_WR) begin
                        exp_wv++;
                        check($sformatf("v%0d b%0d wdata", v, b), 32'(log_wdat[t]), 32'(beats[b].dat));
                    end
                end
            end

            check($sformatf("v%0d busy_count", v),
                  32'(count_busy(n + 1, n + vecs[v].rdy_off)), 32'(exp_busy));
            check($sformatf("v%0d wvalid_count", v),
                  32'(count_wv(n + 1, n + vecs[v].rdy_off)), 32'(exp_wv));
            check($sformatf("v%0d ready_low", v),  32'(log_rdy[n + vecs[v].rdy_off - 1]), 32'd0);
            check($sformatf("v%0d ready_high", v), 32'(log_rdy[n + vecs[v].rdy_off]),     32'd1);
        end

        // NOP followed by SCR held valid, then a second SCR back-to-back; fields
        // change while busy and must only matter at the next acceptance.
        wait_ready();
        n = cyc;
        req_valid = 1'b1;
        drive(F_NOP1, 2'd3, 13'h1111, 10'h3FF, 16'h0000);
        tick();
        drive(F_SCR, 2'd1, 13'h0321, 10'h080, 16'h0000);
        repeat (3) tick();
        drive(F_SCR, 2'd3, 13'h1ABC, 10'h200, 16'h0000);
        while (cyc < n + 12) tick();
        req_valid = 1'b0;
        while (cyc < n + 20) tick();
        check("b2b nop_ready_low",  32'(log_rdy[n + 1]),  32'd0);
        check("b2b nop_ready_high", 32'(log_rdy[n + 2]),  32'd1);
        check("b2b nop_cmd1",       32'(log_cmd[n + 1]),  32'(C_NOP));
        check("b2b nop_cmd2",       32'(log_cmd[n + 2]),  32'(C_NOP));
        check("b2b act1_cmd",       32'(log_cmd[n + 3]),  32'(C_ACT));
        check("b2b act1_row",       32'(log_addr[n + 3]), 32'h0321);
        check("b2b act1_ba",        32'(log_ba[n + 3]),   32'd1);
        check("b2b rd1_cmd",        32'(log_cmd[n + 6]),  32'(C_RD));
        check("b2b rd1_addr",       32'(log_addr[n + 6]), 32'h080);
        check("b2b rd1_ba",         32'(log_ba[n + 6]),   32'd1);
        check("b2b pre1_cmd",       32'(log_cmd[n + 8]),  32'(C_PRE));
        check("b2b ready_at_trp",   32'(log_rdy[n + 11]), 32'd1);
        check("b2b act2_cmd",       32'(log_cmd[n + 12]), 32'(C_ACT));
        check("b2b act2_row",       32'(log_addr[n + 12]), 32'h1ABC);
        check("b2b act2_ba",        32'(log_ba[n + 12]),  32'd3);
        check("b2b rd2_cmd",        32'(log_cmd[n + 15]), 32'(C_RD));
        check("b2b rd2_addr",       32'(log_addr[n + 15]), 32'h200);
        check("b2b ready2_low",     32'(log_rdy[n + 19]), 32'd0);
        check("b2b ready2_high",    32'(log_rdy[n + 20]), 32'd1);

        // Reset between the 2nd and 3rd BLR beat abandons the sequence.
        wait_ready();
        n = cyc;
        req_valid = 1'b1;
        drive(F_BLR, 2'd2, 13'h0777, 10'h000, 16'h0000);
        tick();
        req_valid = 1'b0;
        while (cyc < n + 10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while (cyc < n + 26) tick();
        check("rst_mid beat1_cmd",  32'(log_cmd[n + 4]),   32'(C_RD));
        check("rst_mid beat2_cmd",  32'(log_cmd[n + 8]),   32'(C_RD));
        check("rst_mid beat2_addr", 32'(log_addr[n + 8]),  32'h008);
        check("rst_mid cmd",        32'(log_cmd[n + 11]),  32'(C_NOP));
        check("rst_mid ready",      32'(log_rdy[n + 11]),  32'd0);
        check("rst_mid ba",         32'(log_ba[n + 11]),   32'd0);
        check("rst_mid addr",       32'(log_addr[n + 11]), 32'd0);
        check("rst_mid ready_back", 32'(log_rdy[n + 12]),  32'd1);
        check("rst_mid no_cmds",    32'(count_busy(n + 11, n + 26)), 32'd0);
        check("rst_mid ready_hold", 32'(log_rdy[n + 26]),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
